uart_tx_arbiter: RTL

//  Shares one UART transmitter among NUM_REQ byte-stream requesters. Round-robin grant is

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART-side definitions: byte width and the transmit arbiter state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PACKET = 2'd1,
    ST_GAP    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning last_i+1 upward, wrapping mod N.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    // Walk from the lowest priority to the highest so the nearest candidate wins last.
    for (int i = int'(N); i >= 1; i--) begin
      int              cand;
      logic [IdxW-1:0] cand_idx;
      cand     = (int'(last_i) + i) % int'(N);
      cand_idx = cand[IdxW-1:0];
      if (req_i[cand_idx]) begin
        idx_o = cand_idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams; packet-granular round-robin with an
// optional post-packet idle gap and eviction of an owner that stalls mid-packet.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned IdxW           = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [UART_DATA_BITS*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [UART_DATA_BITS-1:0]           tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic [IdxW-1:0]                     grant_id,
  output logic                                busy,
  output logic                                timeout_evt
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ToW-1:0]  ToLast  = ToW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ToW-1:0]  ToMax   = ToW'(TIMEOUT_CYCLES);
  localparam arb_state_e      StAfter = (GAP_CYCLES != 0) ? ST_GAP : ST_IDLE;

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [ToW-1:0]  idle_q, idle_d;

  logic                      pick_any;
  logic [IdxW-1:0]           pick_idx;
  logic                      owner_valid;
  logic                      owner_last;
  logic [UART_DATA_BITS-1:0] owner_data;
  logic                      to_hit;

  rr_pick #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i  (req_valid),
    .last_i (grant_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign owner_valid = req_valid[grant_q];
  assign owner_last  = req_last[grant_q];
  assign owner_data  = req_data[int'(grant_q) * UART_DATA_BITS +: UART_DATA_BITS];

  // The cycle that would make the idle count reach the limit is the eviction cycle itself.
  assign to_hit = (TIMEOUT_CYCLES != 0) && !owner_valid && (idle_q == ToLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= IdxW'(NUM_REQ - 1);
      gap_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gap_d       = gap_q;
    idle_d      = idle_q;
    tx_valid    = 1'b0;
    tx_data     = '0;
    req_ready   = '0;
    timeout_evt = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_PACKET;
        end
      end

      ST_PACKET: begin
        if (to_hit) begin
          // Evicted index stays in grant_q, so it drops to lowest priority next round.
          timeout_evt = 1'b1;
          idle_d      = '0;
          gap_d       = GapLoad;
          state_d     = StAfter;
        end else begin
          tx_valid           = owner_valid;
          tx_data            = owner_data;
          req_ready[grant_q] = tx_ready;
          if (owner_valid) begin
            idle_d = '0;
          end else if ((TIMEOUT_CYCLES != 0) && (idle_q != ToMax)) begin
            idle_d = idle_q + 1'b1;
          end
          if (owner_valid && tx_ready && owner_last) begin
            idle_d  = '0;
            gap_d   = GapLoad;
            state_d = StAfter;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
